hammu_hamnhan_sched: RTL and testbench

- Two-requester scheduler for the shared multiply/exponent compute core (operands A, B; select 0 = multiply, 1 = exponent; result P with a done flag).
- Arbitrates round-robin between two clients and latches the winner's operands.
- Issues a single-cycle start pulse, waits for done under a timeout watchdog, then returns P or an error to the winning client over a valid/ready response channel.
- Sits between the AXI4-Lite register front-end / DMA clients and the core.

---
 rtl/hammu_hamnhan_sched.sv | 165 ++++++++++++++++
 tb/tb_hammu_hamnhan_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hammu_hamnhan_sched.sv
`default_nettype none
// ============================================================================
// Module   : hammu_hamnhan_sched
// Purpose  : Two-requester round-robin scheduler for the shared
//            multiply/exponent compute core. Captures the winning requester's
//            operands, pulses core_start for one cycle, waits for core_done
//            under a timeout watchdog, then returns the result (or a timeout
//            error) over a per-requester valid/ready response channel.
// Ports    : S_AXI_ACLK / S_AXI_ARESET     clock, async active-high reset
//            req_valid/req_ready/req_a/req_b/req_sel   request channel (x2)
//            rsp_valid/rsp_ready/rsp_data/rsp_err      response channel (x2)
//            core_a/core_b/core_select/core_start/core_done/core_p  core side
//            busy                          high whenever not IDLE
// Revision : 1.0  initial release
// ============================================================================
module hammu_hamnhan_sched #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic            S_AXI_ACLK,
    input  logic            S_AXI_ARESET,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    input  logic [1:0]      req_sel,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_err,
    output logic [DW-1:0]   core_a,
    output logic [DW-1:0]   core_b,
    output logic            core_select,
    output logic            core_start,
    input  logic            core_done,
    input  logic [DW-1:0]   core_p,
    output logic            busy
);

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic            grant_q, grant_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   core_a_q, core_a_d;
    logic [DW-1:0]   core_b_q, core_b_d;
    logic            core_sel_q, core_sel_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic            pick;
    logic            handshake;

    // Both valid: round-robin pointer decides. Otherwise the lone valid
    // requester wins (requester 1 exactly when only bit 1 is set).
    always_comb begin
        pick = (&req_valid) ? rr_ptr_q : req_valid[1];
    end

    // req_ready is gated by reset so every output reads zero while reset is
    // asserted, even if a requester is holding req_valid high.
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == IDLE) && (|req_valid) && !S_AXI_ARESET) begin
            req_ready = pick ? 2'b10 : 2'b01;
        end
    end

    assign handshake   = |(req_valid & req_ready);
    assign rsp_valid   = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    // Decoded from state so async reset removes the pulse immediately.
    assign core_start  = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign core_a      = core_a_q;
    assign core_b      = core_b_q;
    assign core_select = core_sel_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        timer_d    = timer_q;
        core_a_d   = core_a_q;
        core_b_d   = core_b_q;
        core_sel_d = core_sel_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    core_a_d   = pick ? req_a[2*DW-1:DW] : req_a[DW-1:0];
                    core_b_d   = pick ? req_b[2*DW-1:DW] : req_b[DW-1:0];
                    core_sel_d = pick ? req_sel[1] : req_sel[0];
                    grant_d    = pick;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // The first WAIT cycle (timer == 0) may still see a done left
                // over from the previous operation, so it is not trusted.
                // A genuine done on the timeout cycle takes priority.
                if ((timer_q != '0) && core_done) begin
                    rsp_data_d = core_p;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (timer_q == TMO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    rr_ptr_d = ~grant_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            grant_q    <= 1'b0;
            timer_q    <= '0;
            core_a_q   <= '0;
            core_b_q   <= '0;
            core_sel_q <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            timer_q    <= timer_d;
            core_a_q   <= core_a_d;
            core_b_q   <= core_b_d;
            core_sel_q <= core_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hammu_hamnhan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hammu_hamnhan_sched
// Purpose  : Directed self-checking bench for hammu_hamnhan_sched with a
//            behavioural compute-core model and an expected-response queue.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hammu_hamnhan_sched;

    localparam int DW  = 32;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [1:0]      req_sel;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic [DW-1:0]   core_a;
    logic [DW-1:0]   core_b;
    logic            core_select;
    logic            core_start;
    logic            core_done;
    logic [DW-1:0]   core_p;
    logic            busy;

    always #5 clk = ~clk;

    hammu_hamnhan_sched #(.DW(DW), .TIMEOUT(TMO), .TW(7)) dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sel     (req_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_select (core_select),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_p      (core_p),
        .busy        (busy)
    );

    // ---------------- compute core model ----------------
    // Done becomes visible 'delay' cycles after the cycle following start and
    // then stays high (stale) until one cycle after the next start.
    int          delay = 5;
    bit          never = 1'b0;
    logic [DW-1:0] m_p;
    int          m_cnt;
    bit          m_run;
    bit          m_clr;

    function automatic logic [DW-1:0] pow(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = 1;
        for (int k = 0; k < int'(b); k++) r = r * a;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            core_done <= 1'b0;
            core_p    <= '0;
            m_p       <= '0;
            m_run     <= 1'b0;
            m_clr     <= 1'b0;
            m_cnt     <= 0;
        end else if (core_start) begin
            m_p   <= core_select ? pow(core_a, core_b) : core_a * core_b;
            m_cnt <= delay;
            m_run <= 1'b1;
            m_clr <= 1'b1;
        end else begin
            if (m_clr) begin
                core_done <= 1'b0;
                m_clr     <= 1'b0;
            end
            if (m_run) begin
                if (m_cnt <= 1) begin
                    m_run <= 1'b0;
                    if (!never) begin
                        core_done <= 1'b1;
                        core_p    <= m_p;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- cycle / pulse monitor ----------------
    int cyc       = 0;
    int n_start   = 0;
    int start_cyc = 0;
    int n_hs0     = 0;

    always @(posedge clk) begin
        if (core_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if (req_valid[0] && req_ready[0]) n_hs0 <= n_hs0 + 1;
        cyc <= cyc + 1;
    end

    // ---------------- checking ----------------
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present a request, wait (bounded) for its req_ready, queue the expected
    // response and return at the falling edge of the ISSUE cycle.
    task automatic send(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic s, input logic [DW-1:0] p, input logic e);
        int n;
        exp_t x;
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_sel[i]        = s;
        req_valid[i]      = 1'b1;
        #1;
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", 128'(req_ready[i]), 128'd1);
        x.id = i; x.data = p; x.err = e;
        q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    // Wait (bounded) for a response, compare against the queue head, hold
    // off the consumer for 'hold' cycles, then consume it.
    task automatic get_rsp(input int lat, input int hold);
        int   n;
        exp_t e;
        logic [1:0] vexp;
        n = 0;
        while (rsp_valid == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = q.pop_front();
        vexp = (e.id == 1) ? 2'b10 : 2'b01;
        chk("rsp_valid", 128'(rsp_valid), 128'(vexp));
        chk("rsp_data", 128'(rsp_data), 128'(e.data));
        chk("rsp_err", 128'(rsp_err), 128'(e.err));
        chk("latency", 128'(cyc - start_cyc), 128'(lat));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            rsp_ready[1 - e.id] = 1'b1;
            chk("hold", 128'({rsp_valid, rsp_data, rsp_err, req_ready}),
                128'({vexp, e.data, e.err, 2'b00}));
        end
        rsp_ready = 2'b00;
        rsp_ready[e.id] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[e.id] = 1'b0;
        chk("released", 128'({busy, rsp_valid}), 128'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] av [2];
        logic [DW-1:0] bv [2];
        int            n;
        exp_t          x;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_sel   = 2'b00;
        rsp_ready = 2'b00;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({req_ready, rsp_valid, rsp_data, rsp_err, core_a, core_b,
                                   core_select, core_start, busy}), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single multiply, done 5 cycles late -> response 7 cycles after start
        delay = 5;
        send(0, 2, 3, 1'b0, 6, 1'b0);
        chk("t1_issue", 128'({core_start, core_a, core_b, core_select}),
            128'({1'b1, 32'd2, 32'd3, 1'b0}));
        get_rsp(7, 0);
        chk("t1_pulses", 128'({n_start, n_hs0}), 128'({32'd1, 32'd1}));

        // 2: exponent through requester 1 (2**3 = 8)
        delay = 3;
        send(1, 2, 3, 1'b1, 8, 1'b0);
        chk("t2_issue", 128'({core_a, core_b, core_select}), 128'({32'd2, 32'd3, 1'b1}));
        get_rsp(5, 0);

        // 3: contention from reset -> grants alternate 0,1,0,1
        rst = 1'b1;
        av[0] = 3; bv[0] = 4; av[1] = 5; bv[1] = 6;
        req_a = {av[1], av[0]};
        req_b = {bv[1], bv[0]};
        req_sel = 2'b00;
        req_valid = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        delay = 2;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = k % 2;
            #1;
            n = 0;
            while (req_ready == 2'b00 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("grant_order", 128'(req_ready), (w == 1) ? 128'd2 : 128'd1);
            x.id = w; x.data = av[w] * bv[w]; x.err = 1'b0;
            q.push_back(x);
            @(posedge clk);
            @(negedge clk);
            // New operands for the next round; the running op must not see them.
            av[w] = av[w] + 2;
            bv[w] = bv[w] + 1;
            req_a = {av[1], av[0]};
            req_b = {bv[1], bv[0]};
            get_rsp(4, 0);
        end
        req_valid = 2'b00;

        // 4: timeout: WAIT lasts TMO cycles, response TMO+1 after start
        never = 1'b1;
        send(0, 7, 9, 1'b0, 0, 1'b1);
        get_rsp(TMO + 1, 0);
        never = 1'b0;
        delay = 2;
        send(1, 4, 4, 1'b0, 16, 1'b0);
        get_rsp(4, 0);

        // 5: backpressure on requester 0 while requester 1 waits, then
        //    requester 1 served with the previous done still stale at start
        delay = 2;
        send(0, 3, 3, 1'b0, 9, 1'b0);
        req_a[DW +: DW] = 6;
        req_b[DW +: DW] = 7;
        req_sel[1]      = 1'b0;
        req_valid[1]    = 1'b1;
        get_rsp(4, 10);
        send(1, 6, 7, 1'b0, 42, 1'b0);
        get_rsp(4, 0);

        // 6: reset mid-WAIT clears every output before the next edge
        never = 1'b1;
        send(0, 9, 9, 1'b0, 0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t6_busy", 128'({busy, core_a}), 128'({1'b1, 32'd9}));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_reset", 128'({req_ready, rsp_valid, rsp_data, rsp_err, core_a, core_b,
                                    core_select, core_start, busy}), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        never = 1'b0;
        delay = 3;
        send(0, 5, 4, 1'b0, 20, 1'b0);
        get_rsp(5, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
